qerv_rf_ram_1rw: RTL and testbench

- Adapter between the register-file RAM interface (separate read and write ports, read data due one cycle after read enable) and a single-port 1RW SRAM macro.
- Reads always take the SRAM port.
- Writes go to the SRAM in cycles with no read. Otherwise they are parked in a small write buffer and drained in later idle cycles.
- Reads that hit a parked write get forwarded data, so the upstream interface keeps two-port semantics with fixed 1-cycle read latency.

---
 rtl/qerv_rf_pkg.sv | 19 +
 rtl/qerv_rf_ram_1rw_if.sv | 39 +++
 rtl/qerv_rf_wbuf.sv | 90 +++++++++
 rtl/qerv_rf_ram_1rw.sv | 138 +++++++++++++
 tb/tb_qerv_rf_ram_1rw.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/qerv_rf_pkg.sv
// Shared defaults and types for the 1RW register-file RAM adapter.
package qerv_rf_pkg;

  localparam int RF_WIDTH = 8;
  localparam int RF_AW    = 8;

  typedef struct packed {
    logic [RF_AW-1:0]    addr;
    logic [RF_WIDTH-1:0] data;
  } wbuf_ent_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_READ,
    ARB_DRAIN,
    ARB_DIRECT
  } arb_e;

endpackage

// File: rtl/qerv_rf_ram_1rw_if.sv
// RF-side and SRAM-side bus of the 1RW adapter.
// QERV_RF_1RW_PARITY_EN widens the SRAM data by one parity bit.
interface qerv_rf_ram_1rw_if #(
  parameter int width = qerv_rf_pkg::RF_WIDTH,
  parameter int aw    = qerv_rf_pkg::RF_AW
);
`ifdef QERV_RF_1RW_PARITY_EN
  localparam int SW = width + 1;
`else
  localparam int SW = width;
`endif

  logic [aw-1:0]    i_waddr;
  logic [width-1:0] i_wdata;
  logic             i_wen;
  logic [aw-1:0]    i_raddr;
  logic             i_ren;
  logic [width-1:0] o_rdata;
  logic [aw-1:0]    o_sram_addr;
  logic [SW-1:0]    o_sram_wdata;
  logic             o_sram_en;
  logic             o_sram_we;
  logic [SW-1:0]    i_sram_rdata;

  modport slave (
    input  i_waddr, i_wdata, i_wen,
    input  i_raddr, i_ren, i_sram_rdata,
    output o_rdata, o_sram_addr,
    output o_sram_wdata, o_sram_en, o_sram_we
  );

  modport master (
    output i_waddr, i_wdata, i_wen,
    output i_raddr, i_ren, i_sram_rdata,
    input  o_rdata, o_sram_addr,
    input  o_sram_wdata, o_sram_en, o_sram_we
  );

endinterface

// File: rtl/qerv_rf_wbuf.sv
// Write buffer: shifting FIFO (entry 0 is oldest) with
// parallel newest-match address lookup.
module qerv_rf_wbuf
  import qerv_rf_pkg::*;
#(
  parameter int  width = RF_WIDTH,
  parameter int  aw    = RF_AW,
  parameter int  DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [aw-1:0]    push_addr_i,
  input  logic [width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [aw-1:0]    head_addr_o,
  output logic [width-1:0] head_data_o,
  output logic [CW-1:0]    count_o,
  output logic             drop_o,
  input  logic [aw-1:0]    lk_addr_i,
  output logic             hit_o,
  output logic [width-1:0] hit_data_o
);

  logic [aw-1:0]    addr_q [DEPTH];
  logic [aw-1:0]    addr_d [DEPTH];
  logic [width-1:0] data_q [DEPTH];
  logic [width-1:0] data_d [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d, base;

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    base   = cnt_q;
    drop_o = 1'b0;
    if (pop_i && cnt_q != '0) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        addr_d[i] = addr_q[i+1];
        data_d[i] = data_q[i+1];
      end
      base = cnt_q - 1'b1;
    end
    cnt_d = base;
    if (push_i) begin
      if (base == CW'(DEPTH)) begin
        drop_o = 1'b1;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CW'(i) == base) begin
            addr_d[i] = push_addr_i;
            data_d[i] = push_data_i;
          end
        end
        cnt_d = base + 1'b1;
      end
    end
  end

  // later index is newer, so the last match wins
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < cnt_q && addr_q[i] == lk_addr_i) begin
        hit_o      = 1'b1;
        hit_data_o = data_q[i];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign head_addr_o = addr_q[0];
  assign head_data_o = data_q[0];
  assign count_o     = cnt_q;

endmodule

// File: rtl/qerv_rf_ram_1rw.sv
// Two-port RF RAM semantics on a single-port SRAM via a write buffer.
// QERV_RF_1RW_PARITY_EN adds even parity on SRAM data and o_perr.
module qerv_rf_ram_1rw
  import qerv_rf_pkg::*;
#(
  parameter int width = RF_WIDTH,
  parameter int aw    = RF_AW,
  parameter int DEPTH = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  qerv_rf_ram_1rw_if.slave bus,
  output logic o_busy,
`ifdef QERV_RF_1RW_PARITY_EN
  output logic o_perr,
`endif
  output logic o_ovf
);

  localparam int CW = $clog2(DEPTH + 1);

  arb_e             arb;
  logic             go_rd, go_dr, go_dw;
  logic             push, pop, drop;
  logic             lk_hit;
  logic [width-1:0] lk_data, wd;
  logic [aw-1:0]    head_addr;
  logic [width-1:0] head_data;
  logic [CW-1:0]    count;
  logic             hit_q, hit_d;
  logic [width-1:0] fwd_q, fwd_d;
  logic             ovf_q, ovf_d;

  qerv_rf_wbuf #(
    .width(width),
    .aw   (aw),
    .DEPTH(DEPTH)
  ) u_wbuf (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .push_i     (push),
    .push_addr_i(bus.i_waddr),
    .push_data_i(bus.i_wdata),
    .pop_i      (pop),
    .head_addr_o(head_addr),
    .head_data_o(head_data),
    .count_o    (count),
    .drop_o     (drop),
    .lk_addr_i  (bus.i_raddr),
    .hit_o      (lk_hit),
    .hit_data_o (lk_data)
  );

  // reset also silences the SRAM port combinationally
  assign go_rd = !i_rst && bus.i_ren;
  assign go_dr = !i_rst && !bus.i_ren && count != '0;
  assign go_dw = !i_rst && !bus.i_ren && count == '0
               && bus.i_wen;

  always_comb begin
    arb = ARB_IDLE;
    unique case (1'b1)
      go_rd:   arb = ARB_READ;
      go_dr:   arb = ARB_DRAIN;
      go_dw:   arb = ARB_DIRECT;
      default: arb = ARB_IDLE;
    endcase
  end

  always_comb begin
    bus.o_sram_en   = 1'b0;
    bus.o_sram_we   = 1'b0;
    bus.o_sram_addr = bus.i_raddr;
    wd              = '0;
    push            = 1'b0;
    pop             = 1'b0;
    unique case (arb)
      ARB_READ: begin
        bus.o_sram_en = 1'b1;
        push          = bus.i_wen;
      end
      ARB_DRAIN: begin
        bus.o_sram_en   = 1'b1;
        bus.o_sram_we   = 1'b1;
        bus.o_sram_addr = head_addr;
        wd              = head_data;
        pop             = 1'b1;
        push            = bus.i_wen;
      end
      ARB_DIRECT: begin
        bus.o_sram_en   = 1'b1;
        bus.o_sram_we   = 1'b1;
        bus.o_sram_addr = bus.i_waddr;
        wd              = bus.i_wdata;
      end
      default: ;
    endcase
  end

  assign hit_d = go_rd && lk_hit;
  assign fwd_d = go_rd ? lk_data : fwd_q;
  assign ovf_d = ovf_q | drop;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hit_q <= 1'b0;
      fwd_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      hit_q <= hit_d;
      fwd_q <= fwd_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.o_rdata = hit_q ? fwd_q
                     : bus.i_sram_rdata[width-1:0];
  assign o_busy = count != '0;
  assign o_ovf  = ovf_q;

`ifdef QERV_RF_1RW_PARITY_EN
  logic chk_q, chk_d;

  assign bus.o_sram_wdata = {^wd, wd};
  assign chk_d = go_rd && !lk_hit;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) chk_q <= 1'b0;
    else       chk_q <= chk_d;
  end

  // forwarded data never went through the SRAM
  assign o_perr = chk_q && (^bus.i_sram_rdata);
`else
  assign bus.o_sram_wdata = wd;
`endif

endmodule

// File: tb/tb_qerv_rf_ram_1rw.sv
// Scoreboard bench for qerv_rf_ram_1rw with a behavioural SRAM.
module tb_qerv_rf_ram_1rw;
  import qerv_rf_pkg::*;

  localparam int W  = 8;
  localparam int AW = 8;
  localparam int D  = 2;
`ifdef QERV_RF_1RW_PARITY_EN
  localparam int SW = W + 1;
`else
  localparam int SW = W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, ovf;
  logic perr;
  always #5 clk = ~clk;

  qerv_rf_ram_1rw_if #(.width(W), .aw(AW)) bus();

  qerv_rf_ram_1rw #(.width(W), .aw(AW), .DEPTH(D)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus),
    .o_busy(busy),
`ifdef QERV_RF_1RW_PARITY_EN
    .o_perr(perr),
`endif
    .o_ovf (ovf)
  );

`ifndef QERV_RF_1RW_PARITY_EN
  assign perr = 1'b0;
`endif

  logic [SW-1:0] mem [256];
  logic [SW-1:0] sram_q = '0;
  logic          inj = 1'b0;

  function automatic logic [SW-1:0] enc(input logic [W-1:0] d);
`ifdef QERV_RF_1RW_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  always @(posedge clk) begin
    if (bus.o_sram_en) begin
      if (bus.o_sram_we)
        mem[bus.o_sram_addr] <= bus.o_sram_wdata;
      else if (inj)
        sram_q <= mem[bus.o_sram_addr] ^ (SW'(1) << (SW - 1));
      else
        sram_q <= mem[bus.o_sram_addr];
    end
  end
  assign bus.i_sram_rdata = sram_q;

  int n_cmp = 0;
  int n_err = 0;
  wbuf_ent_t    exp_wr[$];
  logic [W:0]   exp_rd[$];
  logic         rd_pend = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // monitor: SRAM writes and read data one cycle after i_ren
  always @(negedge clk) begin
    wbuf_ent_t  e;
    logic [W:0] r;
    if (!rst && bus.o_sram_en && bus.o_sram_we) begin
      if (exp_wr.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL wr_unexp: got write %0h<-%0h, expected none",
                 bus.o_sram_addr, bus.o_sram_wdata);
      end else begin
        e = exp_wr.pop_front();
        chk("wr_addr", 32'(bus.o_sram_addr), 32'(e.addr));
        chk("wr_data", 32'(bus.o_sram_wdata), 32'(enc(e.data)));
      end
    end
    if (rd_pend) begin
      if (exp_rd.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rd_unexp: got %0h, expected none", bus.o_rdata);
      end else begin
        r = exp_rd.pop_front();
        chk("rdata", 32'(bus.o_rdata), 32'(r[W-1:0]));
`ifdef QERV_RF_1RW_PARITY_EN
        chk("perr", 32'(perr), 32'(r[W]));
`endif
      end
    end
    rd_pend <= !rst && bus.i_ren;
  end

  task automatic step(input logic ren, input logic [7:0] ra,
                      input logic wen, input logic [7:0] wa,
                      input logic [7:0] wd);
    @(posedge clk);
    #1;
    bus.i_ren   = ren;
    bus.i_raddr = ra;
    bus.i_wen   = wen;
    bus.i_waddr = wa;
    bus.i_wdata = wd;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= enc(8'h00);
    mem[8'h03] <= enc(8'h33);
    mem[8'h07] <= enc(8'h11);
    mem[8'h05] <= enc(8'h5C);
    bus.i_ren   = 1'b0;
    bus.i_raddr = '0;
    bus.i_wen   = 1'b1;
    bus.i_waddr = 8'h44;
    bus.i_wdata = 8'h99;
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_en", 32'(bus.o_sram_en), 0);
    chk("rst_we", 32'(bus.o_sram_we), 0);
    chk("rst_rdata", 32'(bus.o_rdata), 0);
    chk("rst_perr", 32'(perr), 0);
    #1;
    rst = 1'b0;
    bus.i_wen = 1'b0;

    // direct write while idle
    exp_wr.push_back('{addr: 8'h12, data: 8'hA5});
    step(0, 8'h00, 1, 8'h12, 8'hA5);
    chk("dw_en", 32'(bus.o_sram_en), 1);
    chk("dw_we", 32'(bus.o_sram_we), 1);
    chk("dw_addr", 32'(bus.o_sram_addr), 32'h12);
    chk("dw_busy", 32'(busy), 0);
    idle();
    chk("dw_busy2", 32'(busy), 0);

    // park then forward
    exp_rd.push_back({1'b0, 8'h33});
    exp_wr.push_back('{addr: 8'h12, data: 8'h5A});
    step(1, 8'h03, 1, 8'h12, 8'h5A);
    exp_rd.push_back({1'b0, 8'h5A});
    step(1, 8'h12, 0, 8'h00, 8'h00);
    chk("pk_busy", 32'(busy), 1);
    exp_rd.push_back({1'b0, 8'h5A});
    step(1, 8'h12, 0, 8'h00, 8'h00);
    chk("pk_busy2", 32'(busy), 1);
    idle();
    idle();
    chk("pk_drained", 32'(busy), 0);

    // read-first collision
    exp_rd.push_back({1'b0, 8'h11});
    exp_wr.push_back('{addr: 8'h07, data: 8'hFF});
    step(1, 8'h07, 1, 8'h07, 8'hFF);
    idle();
    exp_rd.push_back({1'b0, 8'hFF});
    step(1, 8'h07, 0, 8'h00, 8'h00);
    idle();

    // newest match wins, drain in arrival order
    exp_rd.push_back({1'b0, 8'h00});
    step(1, 8'h00, 1, 8'h20, 8'h01);
    exp_rd.push_back({1'b0, 8'h00});
    step(1, 8'h01, 1, 8'h20, 8'h02);
    exp_rd.push_back({1'b0, 8'h02});
    exp_wr.push_back('{addr: 8'h20, data: 8'h01});
    exp_wr.push_back('{addr: 8'h20, data: 8'h02});
    step(1, 8'h20, 0, 8'h00, 8'h00);
    idle();
    idle();
    idle();
    chk("nm_busy", 32'(busy), 0);
    exp_rd.push_back({1'b0, 8'h02});
    step(1, 8'h20, 0, 8'h00, 8'h00);
    idle();

    // overflow, sticky, then async reset mid-stream
    exp_rd.push_back({1'b0, 8'h00});
    step(1, 8'h00, 1, 8'h30, 8'hA1);
    exp_rd.push_back({1'b0, 8'h00});
    step(1, 8'h00, 1, 8'h31, 8'hA2);
    chk("ov_pre", 32'(ovf), 0);
    exp_rd.push_back({1'b0, 8'h00});
    step(1, 8'h00, 1, 8'h32, 8'hA3);
    chk("ov_pre2", 32'(ovf), 0);
    exp_wr.push_back('{addr: 8'h30, data: 8'hA1});
    idle();
    chk("ov_set", 32'(ovf), 1);
    exp_rd.push_back({1'b0, 8'h00});
    step(1, 8'h00, 0, 8'h00, 8'h00);
    chk("ov_sticky", 32'(ovf), 1);
    chk("ov_busy", 32'(busy), 1);
    exp_rd.push_back({1'b0, 8'h00});
    step(1, 8'h00, 0, 8'h00, 8'h00);
    #2;
    rst = 1'b1;
    bus.i_ren   = 1'b0;
    bus.i_wen   = 1'b1;
    bus.i_waddr = 8'h40;
    #1;
    chk("ar_ovf", 32'(ovf), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_en", 32'(bus.o_sram_en), 0);
    exp_wr.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.i_wen = 1'b0;
    exp_rd.push_back({1'b0, 8'h00});
    step(1, 8'h31, 0, 8'h00, 8'h00);
    idle();
    chk("ar_ovf2", 32'(ovf), 0);

`ifdef QERV_RF_1RW_PARITY_EN
    // corrupted parity bit on a plain SRAM read
    exp_rd.push_back({1'b1, 8'h5C});
    inj = 1'b1;
    step(1, 8'h05, 0, 8'h00, 8'h00);
    idle();
    inj = 1'b0;
    exp_rd.push_back({1'b0, 8'h5C});
    step(1, 8'h05, 0, 8'h00, 8'h00);
    idle();
`endif

    idle();
    chk("left_rd", 32'(exp_rd.size()), 0);
    chk("left_wr", 32'(exp_wr.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
